// File: rtl/mem_line_responder_if.sv
// mem_line_responder_if: shared C2 line bus between a cache (master) and the memory responder (slave).
// Signals:
//   addr_w  line address, driven by the master in the command cycle
//   cmd_w   shared tri-state command bus (00 NOP, 01 RESPONSE, 10 READ_LINE, 11 WRITE_LINE)
//   data_w  shared tri-state data bus, one beat per cycle
//   m_*/s_* per-side drive values and output enables; the tri-state resolution lives here so
//           each side only states what it wants to drive and when
interface mem_line_responder_if #(
    parameter int ADDR_W      = 10,
    parameter int DATA2_BYTES = 2
);
    localparam int DW = DATA2_BYTES * 8;
    logic [ADDR_W-1:0] addr_w;
    wire  [DW-1:0]     data_w;
    wire  [1:0]        cmd_w;
    logic              m_cmd_oe;
    logic              m_data_oe;
    logic [1:0]        m_cmd;
    logic [DW-1:0]     m_data;
    logic              s_cmd_oe;
    logic              s_data_oe;
    logic [1:0]        s_cmd;
    logic [DW-1:0]     s_data;
    assign cmd_w  = m_cmd_oe  ? m_cmd  : 'z;
    assign cmd_w  = s_cmd_oe  ? s_cmd  : 'z;
    assign data_w = m_data_oe ? m_data : 'z;
    assign data_w = s_data_oe ? s_data : 'z;
    modport master (output addr_w, m_cmd_oe, m_data_oe, m_cmd, m_data, input cmd_w, data_w);
    modport slave  (input addr_w, cmd_w, data_w, output s_cmd_oe, s_data_oe, s_cmd, s_data);
endinterface

// File: rtl/mem_line_responder.sv
// mem_line_responder: C2 line-bus memory responder with a line-organised store and fixed access latency.
// Ports:
//   clk           clock, all sampling and driving on posedge
//   reset         asynchronous, active-high
//   bus           mem_line_responder_if.slave (addr_w, cmd_w, data_w)
//   busy          high whenever the FSM is not IDLE
//   proto_err     sticky; a READ/WRITE command was seen while not IDLE
//   total_reads   completed reads  (only with MEM_RESP_STATS_EN defined)
//   total_writes  completed writes (only with MEM_RESP_STATS_EN defined)
// Optional feature macro: MEM_RESP_STATS_EN adds the transaction counters and their ports.
module mem_line_responder #(
    parameter int ADDR_W      = 10,
    parameter int LINE_BYTES  = 16,
    parameter int DATA2_BYTES = 2,
    parameter int MEM_LATENCY = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_line_responder_if.slave  bus,
    output logic                 busy,
    output logic                 proto_err
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]          total_reads,
    output logic [31:0]          total_writes
`endif
);
    localparam int N     = LINE_BYTES / DATA2_BYTES;
    localparam int DW    = DATA2_BYTES * 8;
    localparam int LW    = LINE_BYTES * 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int BW    = N > 1 ? $clog2(N) : 1;
    localparam int CW    = $clog2(MEM_LATENCY + 1);
    localparam logic [1:0] CMD_RESP = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;
    localparam logic [1:0] CMD_WR   = 2'b11;

    typedef enum logic [1:0] {IDLE, RECV, WAIT, RESP} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_is_wr;
    logic [BW-1:0]     r_beat;
    logic [CW-1:0]     r_cnt;
    logic [LW-1:0]     r_wbuf;

    logic              w_rd;
    logic              w_wr;
    logic              w_last_rx;
    logic              w_done;
    logic              w_commit;
    logic [ADDR_W-1:0] w_waddr;
    logic [BW-1:0]     w_slot;
    logic [LW-1:0]     w_wline;
    logic [LW-1:0]     w_rline;
    logic [LW-1:0]     w_lines [DEPTH];

    // Power-up contents of a line: each byte is its byte address (low 8 bits) xor 5A.
    function automatic logic [LW-1:0] init_line(input int unsigned line);
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < LINE_BYTES; i++) v[8*i +: 8] = 8'(line * LINE_BYTES + i) ^ 8'h5A;
        return v;
    endfunction

    // X/Z on the command bus compares false, so it is treated like NOP.
    assign w_rd      = bus.cmd_w == CMD_RD;
    assign w_wr      = bus.cmd_w == CMD_WR;
    assign w_last_rx = r_state == RECV && r_beat == BW'(N - 1);
    assign w_done    = r_state == RESP && (r_is_wr || r_beat == BW'(N - 1));
    // A line reaches the store only once its final beat is on the bus; reset kills the commit.
    assign w_commit  = !reset && ((r_state == IDLE && w_wr && N == 1) || w_last_rx);
    assign w_waddr   = r_state == IDLE ? bus.addr_w : r_addr;
    assign w_slot    = r_state == IDLE ? '0 : r_beat;

    // Write buffer with the beat currently on the bus merged in, so the last beat commits directly.
    always_comb begin
        w_wline = r_wbuf;
        w_wline[32'(w_slot) * DW +: DW] = bus.data_w;
    end

    assign w_rline       = w_lines[r_addr];
    // Bus drive follows reset combinationally so the bus is freed the moment reset asserts.
    assign bus.s_cmd_oe  = r_state == RESP && !reset;
    assign bus.s_data_oe = r_state == RESP && !reset && !r_is_wr;
    assign bus.s_cmd     = CMD_RESP;
    assign bus.s_data    = w_rline[32'(r_beat) * DW +: DW];

    // Store contents are not touched by reset: committed lines survive it.
    for (genvar g = 0; g < DEPTH; g++) begin : g_line
        logic [LW-1:0] r_line = init_line(g);
        always_ff @(posedge clk) if (w_commit && w_waddr == ADDR_W'(g)) r_line <= w_wline;
        assign w_lines[g] = r_line;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_is_wr   <= 1'b0;
            r_beat    <= '0;
            r_cnt     <= '0;
            r_wbuf    <= '0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (r_state != IDLE && (w_rd || w_wr)) proto_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_rd) begin
                        r_addr  <= bus.addr_w;
                        r_is_wr <= 1'b0;
                        r_cnt   <= CW'(MEM_LATENCY);
                        r_state <= WAIT;
                        busy    <= 1'b1;
                    end else if (w_wr) begin
                        r_addr  <= bus.addr_w;
                        r_is_wr <= 1'b1;
                        r_wbuf  <= w_wline;
                        r_beat  <= BW'(1);
                        r_cnt   <= CW'(MEM_LATENCY);
                        r_state <= N == 1 ? WAIT : RECV;
                        busy    <= 1'b1;
                    end
                end
                RECV: begin
                    r_wbuf <= w_wline;
                    r_beat <= r_beat + 1'b1;
                    if (w_last_rx) begin
                        r_cnt   <= CW'(MEM_LATENCY);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_beat  <= '0;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_beat <= r_beat + 1'b1;
                    if (w_done) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_reads  <= '0;
            total_writes <= '0;
        end else if (w_done) begin
            total_reads  <= total_reads  + 32'(!r_is_wr);
            total_writes <= total_writes + 32'(r_is_wr);
        end
    end
`endif
endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: self-checking bench for mem_line_responder (N=8 and N=1 builds).
module tb_mem_line_responder;
    localparam int L = 100;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_line_responder_if #(.ADDR_W(10), .DATA2_BYTES(2))  bus ();
    mem_line_responder_if #(.ADDR_W(10), .DATA2_BYTES(16)) bus1 ();
    logic busy, proto_err, busy1, proto_err1;
`ifdef MEM_RESP_STATS_EN
    logic [31:0] total_reads, total_writes, total_reads1, total_writes1;
`endif

    mem_line_responder dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .proto_err(proto_err)
`ifdef MEM_RESP_STATS_EN
        , .total_reads(total_reads), .total_writes(total_writes)
`endif
    );

    mem_line_responder #(.DATA2_BYTES(16), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .busy(busy1), .proto_err(proto_err1)
`ifdef MEM_RESP_STATS_EN
        , .total_reads(total_reads1), .total_writes(total_writes1)
`endif
    );

    typedef struct {
        int          cyc;
        bit          wr;
        logic [15:0] data;
        bit          last;
    } exp_t;

    typedef struct {
        bit           wr;
        logic [9:0]   addr;
        logic [127:0] line;
    } vec_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_reads = 0;
    int exp_writes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] init_line(input int a);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'((a * 16 + i) & 255) ^ 8'h5A;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.cmd_w == 2'b01) begin
            check("resp_expected", 128'(q.size() != 0), 128'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                check("resp_cycle", 128'(cyc), 128'(e.cyc));
                if (e.wr) begin
                    check("wr_resp_data_z", 128'(bus.s_data_oe), 128'(0));
                    exp_writes++;
                end else begin
                    check("rd_beat", 128'(bus.data_w), 128'(e.data));
                    if (e.last) exp_reads++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_bus();
        bus.m_cmd_oe  = 1'b0;
        bus.m_data_oe = 1'b0;
    endtask

    task automatic issue_read(input logic [9:0] a, input logic [127:0] exp);
        int c0;
        bus.addr_w   = a;
        bus.m_cmd    = 2'b10;
        bus.m_cmd_oe = 1'b1;
        c0 = cyc + 1;
        for (int k = 0; k < N; k++) q.push_back('{c0 + L + k, 1'b0, exp[16*k +: 16], k == N - 1});
        tick();
        release_bus();
        check("busy_rise_rd", 128'(busy), 128'(1));
    endtask

    task automatic issue_write(input logic [9:0] a, input logic [127:0] line);
        int c0;
        bus.addr_w    = a;
        bus.m_cmd     = 2'b11;
        bus.m_cmd_oe  = 1'b1;
        bus.m_data    = line[15:0];
        bus.m_data_oe = 1'b1;
        c0 = cyc + 1;
        q.push_back('{c0 + N - 1 + L, 1'b1, 16'h0, 1'b1});
        for (int k = 1; k < N; k++) begin
            tick();
            bus.m_cmd_oe = 1'b0;
            bus.m_data   = line[16*k +: 16];
        end
        tick();
        release_bus();
        check("busy_rise_wr", 128'(busy), 128'(1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 400) begin
            tick();
            n++;
        end
        check("drain", 128'({q.size() == 0, busy}), 128'(2'b10));
        check("bus_released", 128'({bus.s_cmd_oe, bus.s_data_oe}), 128'(0));
`ifdef MEM_RESP_STATS_EN
        check("total_reads", 128'(total_reads), 128'(exp_reads));
        check("total_writes", 128'(total_writes), 128'(exp_writes));
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q.delete();
        exp_reads = 0;
        exp_writes = 0;
        release_bus();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v[9];
        logic [127:0] l1, l2, l3, lw1;
        int n;
        release_bus();
        bus.addr_w     = '0;
        bus.m_cmd      = 2'b00;
        bus.m_data     = '0;
        bus1.m_cmd_oe  = 1'b0;
        bus1.m_data_oe = 1'b0;
        bus1.addr_w    = '0;
        bus1.m_cmd     = 2'b00;
        bus1.m_data    = '0;
        l1  = {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        l2  = {$urandom, $urandom, $urandom, $urandom};
        l3  = {$urandom, $urandom, $urandom, $urandom};
        lw1 = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) tick();
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_proto_err", 128'(proto_err), 128'(0));
        check("rst_bus_z", 128'({bus.s_cmd_oe, bus.s_data_oe, bus1.s_cmd_oe, bus1.s_data_oe}), 128'(0));
`ifdef MEM_RESP_STATS_EN
        check("rst_counters", 128'({total_reads, total_writes}), 128'(0));
`endif
        reset = 1'b0;
        tick();

        v[0] = '{1'b0, 10'h005, init_line(10'h005)};
        v[1] = '{1'b1, 10'h3FF, l1};
        v[2] = '{1'b0, 10'h3FF, l1};
        v[3] = '{1'b0, 10'h000, init_line(10'h000)};
        v[4] = '{1'b1, 10'h123, l2};
        v[5] = '{1'b0, 10'h123, l2};
        v[6] = '{1'b0, 10'h124, init_line(10'h124)};
        v[7] = '{1'b1, 10'h3FF, l3};
        v[8] = '{1'b0, 10'h3FF, l3};
        for (int i = 0; i < 9; i++) begin
            if (v[i].wr) issue_write(v[i].addr, v[i].line);
            else issue_read(v[i].addr, v[i].line);
            wait_idle();
        end

        // back-to-back reads: second command driven so it is sampled on the edge after release
        do_reset();
        issue_read(10'h002, init_line(10'h002));
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check("b2b_first_done", 128'(busy), 128'(0));
        issue_read(10'h003, init_line(10'h003));
        wait_idle();

        // reset after beat 4 of a write: nothing committed, bus free, busy low
        tick();
        bus.addr_w    = 10'h010;
        bus.m_cmd     = 2'b11;
        bus.m_cmd_oe  = 1'b1;
        bus.m_data    = 16'hAAAA;
        bus.m_data_oe = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus.m_cmd_oe = 1'b0;
            bus.m_data   = 16'hAAAA + 16'(k);
        end
        tick();
        release_bus();
        check("mid_wr_busy", 128'(busy), 128'(1));
        reset = 1'b1;
        #1;
        check("mid_wr_rst_busy", 128'(busy), 128'(0));
        check("mid_wr_rst_bus", 128'({bus.s_cmd_oe, bus.s_data_oe}), 128'(0));
        do_reset();
        issue_read(10'h010, init_line(10'h010));
        wait_idle();

        // reset while the read response is on the bus
        issue_read(10'h020, init_line(10'h020));
        n = 0;
        while (bus.s_cmd_oe !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("resp_seen", 128'(bus.s_cmd_oe), 128'(1));
        tick();
        reset = 1'b1;
        #1;
        check("resp_rst_bus", 128'({bus.s_cmd_oe, bus.s_data_oe}), 128'(0));
        check("resp_rst_busy", 128'(busy), 128'(0));
        do_reset();
        issue_read(10'h3FF, l3);
        wait_idle();

        // command during WAIT is ignored and flags proto_err
        issue_read(10'h007, init_line(10'h007));
        repeat (5) tick();
        bus.addr_w   = 10'h3FF;
        bus.m_cmd    = 2'b10;
        bus.m_cmd_oe = 1'b1;
        tick();
        release_bus();
        check("proto_err_set", 128'(proto_err), 128'(1));
        wait_idle();
        check("proto_err_sticky", 128'(proto_err), 128'(1));
        do_reset();
        check("proto_err_cleared", 128'(proto_err), 128'(0));

        // single-beat, latency-1 instance
        bus1.addr_w    = 10'h001;
        bus1.m_cmd     = 2'b11;
        bus1.m_cmd_oe  = 1'b1;
        bus1.m_data    = lw1;
        bus1.m_data_oe = 1'b1;
        tick();
        bus1.m_cmd_oe  = 1'b0;
        bus1.m_data_oe = 1'b0;
        check("n1_wr_busy", 128'(busy1), 128'(1));
        check("n1_wr_no_early_resp", 128'(bus1.s_cmd_oe), 128'(0));
        tick();
        check("n1_wr_resp", 128'(bus1.cmd_w), 128'(2'b01));
        check("n1_wr_data_z", 128'(bus1.s_data_oe), 128'(0));
        tick();
        check("n1_wr_release", 128'({bus1.s_cmd_oe, busy1}), 128'(0));
        bus1.m_cmd    = 2'b10;
        bus1.m_cmd_oe = 1'b1;
        tick();
        bus1.m_cmd_oe = 1'b0;
        check("n1_rd_no_early_resp", 128'(bus1.s_cmd_oe), 128'(0));
        tick();
        check("n1_rd_resp", 128'(bus1.cmd_w), 128'(2'b01));
        check("n1_rd_data", bus1.data_w, lw1);
        tick();
        check("n1_rd_release", 128'({bus1.s_cmd_oe, busy1}), 128'(0));
        bus1.addr_w   = 10'h002;
        bus1.m_cmd_oe = 1'b1;
        repeat (2) tick();
        bus1.m_cmd_oe = 1'b0;
        check("n1_init_data", bus1.data_w, init_line(10'h002));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
